// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Optional feature macro: MC_ADDI_EN (addi through ADDIEX/ADDIWB).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: operation class plus funct field to ALU code.
// funct_illegal flags an R-type funct the datapath does not implement.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  // Map operation class and funct to an ALU code
  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: one state per clock,
// Moore-decoded datapath controls, retired-instruction counter, sticky halt.
// Optional feature macro: MC_ADDI_EN (addi support through ADDIEX/ADDIWB).
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t  state;
  alu_op_t alu_op;
  logic    funct_illegal;

  mc_alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal)
  );

  // Sequence each instruction through its states; HALT holds until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  if (run) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI:      state <= ADDIEX;
`endif
            default:      state <= HALT;
          endcase
        end
        MEMADR: begin
          if (opcode == OP_SW) state <= MEMWR;
          else                 state <= MEMRD;
        end
        MEMRD:  state <= MEMWB;
        EXEC: begin
          if (funct_illegal) state <= HALT;
          else               state <= ALUWB;
        end
`ifdef MC_ADDI_EN
        ADDIEX: state <= ADDIWB;
        ADDIWB: state <= FETCH;
`endif
        MEMWB, MEMWR, ALUWB, BRANCH, JUMP: state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Decode datapath controls from the current state (run/zero/funct gate a few)
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    retire     = 1'b0;
    halted     = 1'b0;
    alu_op     = ALUOP_ADD;
    case (state)
      FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = run;
        pc_en     = run;
      end
      DECODE: alu_src_b = SRCB_IMMSH;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        retire    = 1'b1;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
`endif
      JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  // Count retired instructions; wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

endmodule
